bist_sig_checker: RTL and testbench

BIST_SIG_CHECKER -- requirements
Module: bist_sig_checker

---
 rtl/bist_pkg.sv | 19 +
 rtl/sig_unload_shifter.sv | 43 ++++
 rtl/bist_sig_checker.sv | 189 ++++++++++++++++++
 tb/tb_bist_sig_checker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared defaults, FSM encoding and small helpers for the BIST signature checker.
package bist_pkg;

  localparam int DEF_MISR_SIZE  = 32;
  localparam int DEF_MISR2_SIZE = 12;
  localparam int DEF_NUM_CFG    = 8;
  localparam int DEF_SIG_W      = DEF_MISR_SIZE + DEF_MISR2_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_UNLOAD  = 2'd2
  } bist_state_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sig_unload_shifter.sv
// Capture register for the session signature with MSB-first shift-out and
// a cycle counter that flags the last unload cycle.
module sig_unload_shifter #(
  parameter int SIG_W = 44
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [SIG_W-1:0] load_data,
  input  logic             shift_en,
  output logic [SIG_W-1:0] cap_reg,
  output logic             msb,
  output logic             last
);

  localparam int CNT_W = $clog2(SIG_W);

  logic [CNT_W-1:0] cnt;

  assign msb  = cap_reg[SIG_W-1];
  assign last = shift_en && (cnt == CNT_W'(SIG_W - 1));

  // Capture on load, shift left while unloading; clr only restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_reg <= {SIG_W{1'b0}};
      cnt     <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt     <= {CNT_W{1'b0}};
    end else if (load) begin
      cap_reg <= load_data;
      cnt     <= {CNT_W{1'b0}};
    end else if (shift_en) begin
      cap_reg <= {cap_reg[SIG_W-2:0], 1'b0};
      cnt     <= last ? {CNT_W{1'b0}} : cnt + CNT_W'(1);
    end else begin
      cap_reg <= cap_reg;
      cnt     <= cnt;
    end
  end

endmodule

// File: rtl/bist_sig_checker.sv
// Compares each BIST session signature against a per-session golden entry,
// keeps pass/fail statistics and serially unloads the captured signature.
module bist_sig_checker
  import bist_pkg::*;
#(
  parameter int MISR_Size  = DEF_MISR_SIZE,
  parameter int MISR2_Size = DEF_MISR2_SIZE,
  parameter int NUM_CFG    = DEF_NUM_CFG
) (
  input  logic                                  clk,
  input  logic                                  masterRst,
  input  logic                                  done,
  input  logic [MISR_Size-1:0]                  misrSig,
  input  logic [MISR2_Size-1:0]                 misr2Sig,
  input  logic                                  gWrEn,
  input  logic [$clog2(NUM_CFG)-1:0]            gWrAddr,
  input  logic [MISR_Size+MISR2_Size-1:0]       gWrData,
  input  logic                                  cfgClr,
  output logic                                  busy,
  output logic                                  result,
  output logic                                  resultVal,
  output logic [3:0]                            passCnt,
  output logic [3:0]                            failCnt,
  output logic [$clog2(NUM_CFG)-1:0]            cfgIdx,
  output logic                                  sigOut,
  output logic                                  sigOutVal,
  output logic                                  allDone,
  output logic                                  overrun
);

  localparam int SIG_W = MISR_Size + MISR2_Size;
  localparam int IDX_W = $clog2(NUM_CFG);

  bist_state_e state, next_state;

  logic             done_d;
  logic             done_edge;
  logic [SIG_W-1:0] golden [NUM_CFG];
  logic [SIG_W-1:0] cap_reg;
  logic             shift_msb;
  logic             shift_last;
  logic             cap_load;
  logic             shift_en;
  logic             match;

  logic             result_n;
  logic             result_val_n;
  logic [3:0]       pass_n;
  logic [3:0]       fail_n;
  logic [IDX_W-1:0] idx_n;
  logic             all_done_n;
  logic             overrun_n;
  logic             sig_out_n;
  logic             sig_val_n;
  logic             busy_n;

  assign done_edge = done && !done_d;
  assign cap_load  = (state == ST_IDLE) && done_edge && !cfgClr;
  assign shift_en  = (state == ST_UNLOAD) && !cfgClr;
  assign match     = (cap_reg == golden[cfgIdx]);

  sig_unload_shifter #(
    .SIG_W (SIG_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (masterRst),
    .clr       (cfgClr),
    .load      (cap_load),
    .load_data ({misrSig, misr2Sig}),
    .shift_en  (shift_en),
    .cap_reg   (cap_reg),
    .msb       (shift_msb),
    .last      (shift_last)
  );

  // Golden table: reads see the pre-write contents in the cycle of a write.
  always_ff @(posedge clk or posedge masterRst) begin
    if (masterRst) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        golden[i] <= {SIG_W{1'b0}};
      end
    end else if (gWrEn) begin
      golden[gWrAddr] <= gWrData;
    end else begin
      golden[gWrAddr] <= golden[gWrAddr];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge masterRst) begin
    if (masterRst) begin
      state  <= ST_IDLE;
      done_d <= 1'b0;
    end else begin
      state  <= next_state;
      done_d <= done;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    if (cfgClr) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    next_state = done_edge ? ST_COMPARE : ST_IDLE;
        ST_COMPARE: next_state = ST_UNLOAD;
        ST_UNLOAD:  next_state = shift_last ? ST_IDLE : ST_UNLOAD;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  // Output logic; busy also spans the final registered unload bit.
  always_comb begin
    result_n     = result;
    result_val_n = 1'b0;
    pass_n       = passCnt;
    fail_n       = failCnt;
    idx_n        = cfgIdx;
    all_done_n   = allDone;
    overrun_n    = overrun;
    sig_out_n    = 1'b0;
    sig_val_n    = 1'b0;
    if (cfgClr) begin
      result_n   = 1'b0;
      pass_n     = 4'd0;
      fail_n     = 4'd0;
      idx_n      = {IDX_W{1'b0}};
      all_done_n = 1'b0;
      overrun_n  = 1'b0;
    end else begin
      overrun_n = overrun || (done_edge && (state != ST_IDLE));
      case (state)
        ST_COMPARE: begin
          result_n     = match;
          result_val_n = 1'b1;
          if (match) begin
            pass_n = sat_inc4(passCnt);
          end else begin
            fail_n = sat_inc4(failCnt);
          end
        end
        ST_UNLOAD: begin
          sig_out_n = shift_msb;
          sig_val_n = 1'b1;
          if (shift_last) begin
            idx_n      = cfgIdx + IDX_W'(1);
            all_done_n = allDone || (cfgIdx == IDX_W'(NUM_CFG - 1));
          end else begin
            idx_n = cfgIdx;
          end
        end
        ST_IDLE:    result_n = result;
        default:    result_n = result;
      endcase
    end
    busy_n = (next_state != ST_IDLE) || sig_val_n;
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge masterRst) begin
    if (masterRst) begin
      busy      <= 1'b0;
      result    <= 1'b0;
      resultVal <= 1'b0;
      passCnt   <= 4'd0;
      failCnt   <= 4'd0;
      cfgIdx    <= {IDX_W{1'b0}};
      sigOut    <= 1'b0;
      sigOutVal <= 1'b0;
      allDone   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      busy      <= busy_n;
      result    <= result_n;
      resultVal <= result_val_n;
      passCnt   <= pass_n;
      failCnt   <= fail_n;
      cfgIdx    <= idx_n;
      sigOut    <= sig_out_n;
      sigOutVal <= sig_val_n;
      allDone   <= all_done_n;
      overrun   <= overrun_n;
    end
  end

endmodule

// File: tb/tb_bist_sig_checker.sv
// Directed self-checking bench for bist_sig_checker.
module tb_bist_sig_checker;

  logic        clk = 1'b0;
  logic        masterRst;
  logic        done;
  logic [31:0] misrSig;
  logic [11:0] misr2Sig;
  logic        gWrEn;
  logic [2:0]  gWrAddr;
  logic [43:0] gWrData;
  logic        cfgClr;
  logic        busy, result, resultVal, sigOut, sigOutVal, allDone, overrun;
  logic [3:0]  passCnt, failCnt;
  logic [2:0]  cfgIdx;

  int n_tests = 0;
  int n_fail  = 0;

  bist_sig_checker dut (
    .clk       (clk),
    .masterRst (masterRst),
    .done      (done),
    .misrSig   (misrSig),
    .misr2Sig  (misr2Sig),
    .gWrEn     (gWrEn),
    .gWrAddr   (gWrAddr),
    .gWrData   (gWrData),
    .cfgClr    (cfgClr),
    .busy      (busy),
    .result    (result),
    .resultVal (resultVal),
    .passCnt   (passCnt),
    .failCnt   (failCnt),
    .cfgIdx    (cfgIdx),
    .sigOut    (sigOut),
    .sigOutVal (sigOutVal),
    .allDone   (allDone),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_golden(input logic [2:0] addr, input logic [43:0] data);
    @(negedge clk);
    gWrEn = 1'b1; gWrAddr = addr; gWrData = data;
    @(negedge clk);
    gWrEn = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    cfgClr = 1'b1;
    @(negedge clk);
    cfgClr = 1'b0;
  endtask

  // Full session with done held high throughout; checks strobe, counts, stream, index.
  task automatic run_session(input string tag, input logic [31:0] m, input logic [11:0] m2,
                             input logic exp_res, input logic [3:0] exp_pass,
                             input logic [3:0] exp_fail, input logic [2:0] exp_idx);
    logic [43:0] stream;
    logic        val_all;
    logic        rv_extra;
    stream = 44'h0; val_all = 1'b1; rv_extra = 1'b0;
    @(negedge clk);
    misrSig = m; misr2Sig = m2; done = 1'b1;
    @(negedge clk);
    check_eq({tag, "_busy"}, busy, 1);
    check_eq({tag, "_rv_e0"}, resultVal, 0);
    @(negedge clk);
    check_eq({tag, "_rv_e1"}, resultVal, 1);
    check_eq({tag, "_result"}, result, exp_res);
    check_eq({tag, "_pass"}, passCnt, exp_pass);
    check_eq({tag, "_fail"}, failCnt, exp_fail);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      val_all  = val_all & sigOutVal;
      rv_extra = rv_extra | resultVal;
      stream   = {stream[42:0], sigOut};
    end
    check_eq({tag, "_stream"}, stream, {m, m2});
    check_eq({tag, "_val_all"}, val_all, 1);
    check_eq({tag, "_rv_once"}, rv_extra, 0);
    @(negedge clk);
    check_eq({tag, "_val_end"}, sigOutVal, 0);
    check_eq({tag, "_busy_end"}, busy, 0);
    check_eq({tag, "_idx"}, cfgIdx, exp_idx);
    done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra_rv;
    int rv_seen;
    masterRst = 1'b1; done = 1'b0; misrSig = 32'h0; misr2Sig = 12'h0;
    gWrEn = 1'b0; gWrAddr = 3'd0; gWrData = 44'h0; cfgClr = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_rv", resultVal, 0);
    check_eq("rst_pass", passCnt, 0);
    check_eq("rst_fail", failCnt, 0);
    check_eq("rst_idx", cfgIdx, 0);
    check_eq("rst_sov", sigOutVal, 0);
    check_eq("rst_alldone", allDone, 0);
    check_eq("rst_overrun", overrun, 0);
    masterRst = 1'b0;

    // Matching session on entry 0.
    write_golden(3'd0, 44'h0123456789A);
    run_session("match", 32'h01234567, 12'h89A, 1'b1, 4'd1, 4'd0, 3'd1);

    // Single-bit mismatch on entry 0.
    pulse_clr();
    check_eq("clr_idx", cfgIdx, 0);
    check_eq("clr_pass", passCnt, 0);
    run_session("mism", 32'h01234567, 12'h89B, 1'b0, 4'd0, 4'd1, 3'd1);

    // Sixteen mismatches: saturation and index wrap.
    pulse_clr();
    for (int s = 1; s <= 16; s++) begin
      run_session("sat", 32'hFFFFFFFF, 12'hFFF, 1'b0, 4'd0,
                  (s > 15) ? 4'd15 : 4'(s), 3'(s % 8));
      if (s == 7) check_eq("alldone_s7", allDone, 0);
      if (s == 8) check_eq("alldone_s8", allDone, 1);
    end
    check_eq("sat_fail", failCnt, 15);
    check_eq("sat_idx", cfgIdx, 0);

    // Second done edge during unload.
    pulse_clr();
    @(negedge clk);
    misrSig = 32'h01234567; misr2Sig = 12'h89A; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check_eq("ovr_rv", resultVal, 1);
    repeat (10) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check_eq("ovr_flag", overrun, 1);
    extra_rv = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      @(negedge clk);
      extra_rv += int'(resultVal);
    end
    check_eq("ovr_idle", busy, 0);
    check_eq("ovr_extra_rv", extra_rv, 0);
    check_eq("ovr_pass", passCnt, 1);
    check_eq("ovr_fail", failCnt, 0);
    check_eq("ovr_idx", cfgIdx, 1);

    // cfgClr in the middle of unload.
    @(negedge clk);
    misrSig = 32'h01234567; misr2Sig = 12'h89A; done = 1'b1;
    repeat (21) @(negedge clk);
    check_eq("mid_sov_pre", sigOutVal, 1);
    cfgClr = 1'b1;
    @(negedge clk);
    cfgClr = 1'b0;
    check_eq("clr_sov", sigOutVal, 0);
    check_eq("clr_busy", busy, 0);
    check_eq("clr_pass2", passCnt, 0);
    check_eq("clr_idx2", cfgIdx, 0);
    check_eq("clr_overrun", overrun, 0);
    check_eq("clr_result", result, 0);
    done = 1'b0;
    run_session("kept", 32'h01234567, 12'h89A, 1'b1, 4'd1, 4'd0, 3'd1);

    // Asynchronous reset during COMPARE.
    @(negedge clk);
    misrSig = 32'h0; misr2Sig = 12'h0; done = 1'b1;
    @(negedge clk);
    masterRst = 1'b1;
    #1;
    check_eq("ar_busy", busy, 0);
    check_eq("ar_rv", resultVal, 0);
    check_eq("ar_result", result, 0);
    check_eq("ar_pass", passCnt, 0);
    check_eq("ar_idx", cfgIdx, 0);
    check_eq("ar_sov", sigOutVal, 0);
    @(negedge clk);
    masterRst = 1'b0; done = 1'b0;
    rv_seen = 0;
    repeat (5) begin
      @(negedge clk);
      rv_seen += int'(resultVal);
    end
    check_eq("ar_no_rv", rv_seen, 0);
    run_session("zero", 32'h0, 12'h0, 1'b1, 4'd1, 4'd0, 3'd1);
    run_session("gold1", 32'h01234567, 12'h89A, 1'b0, 4'd1, 4'd1, 3'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
